// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one block-wide memory interface between I-cache (port 0) and D-cache (port 1).
// Optional saturating performance counters are enabled with `define MEM_ARBITER_PERF_CNT_EN.
module mem_arbiter #(
  parameter int ARB_MODE       = 0,
  parameter int RELEASE_CYCLES = 1
) (
  input  logic         clk,
  input  logic         proc_reset_n,
  input  logic         p0_read,
  input  logic         p0_write,
  input  logic [27:0]  p0_addr,
  input  logic [127:0] p0_wdata,
  output logic [127:0] p0_rdata,
  output logic         p0_ready,
  input  logic         p1_read,
  input  logic         p1_write,
  input  logic [27:0]  p1_addr,
  input  logic [127:0] p1_wdata,
  output logic [127:0] p1_rdata,
  output logic         p1_ready,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
`ifdef MEM_ARBITER_PERF_CNT_EN
  ,
  output logic [15:0]  perf_grant0,
  output logic [15:0]  perf_grant1,
  output logic [15:0]  perf_wait
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t       state_reg, state_next;
  logic         grant_reg, grant_next;
  logic         rr_last_reg, rr_last_next;
  logic [1:0]   rel_cnt_reg, rel_cnt_next;
  logic         mem_read_reg, mem_read_next;
  logic         mem_write_reg, mem_write_next;
  logic [27:0]  mem_addr_reg, mem_addr_next;
  logic [127:0] mem_wdata_reg, mem_wdata_next;

  logic [1:0]   req_vec;
  logic [1:0]   ready_vec;
  logic         winner;
  logic         win_read, win_write;
  logic [27:0]  win_addr;
  logic [127:0] win_wdata;

  assign req_vec[0] = p0_read | p0_write;
  assign req_vec[1] = p1_read | p1_write;

  // Completion pulse is steered only to the granted port, and only while BUSY.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = (state_reg == BUSY) && mem_ready && (int'(grant_reg) == gi);
    end
  endgenerate

  assign p0_ready = ready_vec[0];
  assign p1_ready = ready_vec[1];
  assign p0_rdata = mem_rdata;
  assign p1_rdata = mem_rdata;

  always_comb begin
    winner = 1'b0;
    if (req_vec[0] && req_vec[1]) begin
      winner = (ARB_MODE == 1) ? 1'b1 : ~rr_last_reg;
    end else if (req_vec[1]) begin
      winner = 1'b1;
    end
  end

  // A simultaneous read+write on one port is forwarded as a write.
  assign win_write = winner ? p1_write : p0_write;
  assign win_read  = winner ? (p1_read & ~p1_write) : (p0_read & ~p0_write);
  assign win_addr  = winner ? p1_addr : p0_addr;
  assign win_wdata = winner ? p1_wdata : p0_wdata;

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    rr_last_next   = rr_last_reg;
    rel_cnt_next   = rel_cnt_reg;
    mem_read_next  = mem_read_reg;
    mem_write_next = mem_write_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    case (state_reg)
      IDLE: begin
        if (|req_vec) begin
          grant_next     = winner;
          rr_last_next   = winner;
          mem_read_next  = win_read;
          mem_write_next = win_write;
          mem_addr_next  = win_addr;
          mem_wdata_next = win_wdata;
          state_next     = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          mem_read_next  = 1'b0;
          mem_write_next = 1'b0;
          rel_cnt_next   = 2'(RELEASE_CYCLES);
          state_next     = RELEASE;
        end
      end
      RELEASE: begin
        rel_cnt_next = rel_cnt_reg - 2'd1;
        if (rel_cnt_reg <= 2'd1) begin
          rel_cnt_next = 2'd0;
          state_next   = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_reg     <= IDLE;
      grant_reg     <= 1'b0;
      rr_last_reg   <= 1'b1;
      rel_cnt_reg   <= 2'd0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      mem_addr_reg  <= 28'd0;
      mem_wdata_reg <= 128'd0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      rr_last_reg   <= rr_last_next;
      rel_cnt_reg   <= rel_cnt_next;
      mem_read_reg  <= mem_read_next;
      mem_write_reg <= mem_write_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
    end
  end

  assign mem_read  = mem_read_reg;
  assign mem_write = mem_write_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

`ifdef MEM_ARBITER_PERF_CNT_EN
  logic [15:0] perf_grant0_reg, perf_grant1_reg, perf_wait_reg;
  logic        wait_cycle;

  // A port is waiting whenever it requests and is not the one currently being served.
  assign wait_cycle = (req_vec[0] && !((state_reg == BUSY) && (grant_reg == 1'b0))) ||
                      (req_vec[1] && !((state_reg == BUSY) && (grant_reg == 1'b1)));

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      perf_grant0_reg <= 16'd0;
      perf_grant1_reg <= 16'd0;
      perf_wait_reg   <= 16'd0;
    end else begin
      if (ready_vec[0] && (perf_grant0_reg != 16'hFFFF)) perf_grant0_reg <= perf_grant0_reg + 16'd1;
      if (ready_vec[1] && (perf_grant1_reg != 16'hFFFF)) perf_grant1_reg <= perf_grant1_reg + 16'd1;
      if (wait_cycle && (perf_wait_reg != 16'hFFFF))     perf_wait_reg   <= perf_wait_reg + 16'd1;
    end
  end

  assign perf_grant0 = perf_grant0_reg;
  assign perf_grant1 = perf_grant1_reg;
  assign perf_wait   = perf_wait_reg;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: round-robin instance u_dut plus a fixed-priority instance u_dut1 on shared inputs.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         proc_reset_n;
  logic         p0_read, p0_write, p1_read, p1_write;
  logic [27:0]  p0_addr, p1_addr;
  logic [127:0] p0_wdata, p1_wdata;
  logic [127:0] p0_rdata, p1_rdata;
  logic         p0_ready, p1_ready;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  logic [127:0] d1_p0_rdata, d1_p1_rdata;
  logic         d1_p0_ready, d1_p1_ready;
  logic         d1_mem_read, d1_mem_write;
  logic [27:0]  d1_mem_addr;
  logic [127:0] d1_mem_wdata;

`ifdef MEM_ARBITER_PERF_CNT_EN
  logic [15:0] pg0, pg1, pw, d1_pg0, d1_pg1, d1_pw;
`endif

  typedef struct {
    bit           port;
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
  } req_t;

  req_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ARB_MODE(0), .RELEASE_CYCLES(1)) u_dut (
    .clk(clk), .proc_reset_n(proc_reset_n),
    .p0_read(p0_read), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_ready(p0_ready),
    .p1_read(p1_read), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_ready(p1_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef MEM_ARBITER_PERF_CNT_EN
    , .perf_grant0(pg0), .perf_grant1(pg1), .perf_wait(pw)
`endif
  );

  mem_arbiter #(.ARB_MODE(1), .RELEASE_CYCLES(1)) u_dut1 (
    .clk(clk), .proc_reset_n(proc_reset_n),
    .p0_read(p0_read), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(d1_p0_rdata), .p0_ready(d1_p0_ready),
    .p1_read(p1_read), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(d1_p1_rdata), .p1_ready(d1_p1_ready),
    .mem_read(d1_mem_read), .mem_write(d1_mem_write), .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef MEM_ARBITER_PERF_CNT_EN
    , .perf_grant0(d1_pg0), .perf_grant1(d1_pg1), .perf_wait(d1_pw)
`endif
  );

  task automatic do_reset();
    proc_reset_n = 1'b0;
    p0_read = 0; p0_write = 0; p0_addr = '0; p0_wdata = '0;
    p1_read = 0; p1_write = 0; p1_addr = '0; p1_wdata = '0;
    mem_rdata = '0; mem_ready = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    proc_reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Memory responder: pops the expected request, checks what memory sees, then completes it.
  task automatic serve(input int latency, input logic [127:0] rdata, input int hold, input int exp_wait);
    req_t e;
    int   waited;
    waited = 0;
    while (!(mem_read || mem_write) && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL sb_empty got_req=%0b required=queued entry", mem_read | mem_write);
      return;
    end
    e = exp_q.pop_front();
    if (!(mem_read || mem_write)) begin
      n_fail++; $display("FAIL req_timeout got=no request required=request for addr %0h", e.addr);
      p0_read = 0; p0_write = 0; p1_read = 0; p1_write = 0;
      return;
    end
    if (exp_wait >= 0) begin
      n_checks++;
      if (waited != exp_wait) begin n_fail++; $display("FAIL req_latency got=%0d required=%0d", waited, exp_wait); end
    end
    n_checks++;
    if ({mem_write, mem_read} !== {e.wr, !e.wr}) begin
      n_fail++; $display("FAIL mem_op got w=%0b r=%0b required w=%0b r=%0b", mem_write, mem_read, e.wr, !e.wr);
    end
    n_checks++;
    if (mem_addr !== e.addr) begin n_fail++; $display("FAIL mem_addr got=%0h required=%0h", mem_addr, e.addr); end
    if (e.wr) begin
      n_checks++;
      if (mem_wdata !== e.wdata) begin n_fail++; $display("FAIL mem_wdata got=%0h required=%0h", mem_wdata, e.wdata); end
    end
    for (int i = 1; i < latency; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({p1_ready, p0_ready} !== 2'b00 || mem_addr !== e.addr) begin
        n_fail++; $display("FAIL busy_hold got rdy=%b addr=%0h required rdy=00 addr=%0h", {p1_ready, p0_ready}, mem_addr, e.addr);
      end
    end
    mem_rdata = rdata; mem_ready = 1'b1; #1;
    n_checks++;
    if ({p1_ready, p0_ready} !== (e.port ? 2'b10 : 2'b01)) begin
      n_fail++; $display("FAIL ready_route got=%b required=%b", {p1_ready, p0_ready}, (e.port ? 2'b10 : 2'b01));
    end
    n_checks++;
    if ((e.port ? p1_rdata : p0_rdata) !== rdata) begin
      n_fail++; $display("FAIL rdata got=%0h required=%0h", (e.port ? p1_rdata : p0_rdata), rdata);
    end
    @(posedge clk); #1;
    mem_ready = 1'b0; #1;
    n_checks++;
    if ({p1_ready, p0_ready, mem_read, mem_write} !== 4'b0000) begin
      n_fail++; $display("FAIL release_clear got rdy=%b r=%0b w=%0b required all 0", {p1_ready, p0_ready}, mem_read, mem_write);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    if (e.port) begin p1_read = 0; p1_write = 0; end
    else begin p0_read = 0; p0_write = 0; end
    $display("txn port=%0d %s addr=%07h wait=%0d", e.port, e.wr ? "WR" : "RD", e.addr, waited);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({mem_read, mem_write, mem_addr, mem_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_mem got r=%0b w=%0b a=%0h d=%0h required 0", mem_read, mem_write, mem_addr, mem_wdata);
    end
    mem_rdata = {4{32'hDEADBEEF}}; mem_ready = 1'b1; #1;
    n_checks++;
    if ({p1_ready, p0_ready} !== 2'b00) begin n_fail++; $display("FAIL idle_ready got=%b required=00", {p1_ready, p0_ready}); end
    n_checks++;
    if (p0_rdata !== {4{32'hDEADBEEF}} || p1_rdata !== {4{32'hDEADBEEF}}) begin
      n_fail++; $display("FAIL rdata_pass got=%0h/%0h required=%0h", p0_rdata, p1_rdata, {4{32'hDEADBEEF}});
    end
    @(posedge clk); #1;
    mem_ready = 1'b0;
    n_checks++;
    if ({mem_read, mem_write} !== 2'b00) begin n_fail++; $display("FAIL idle_ignore got=%b required=00", {mem_read, mem_write}); end
  endtask

  task automatic test_single_read();
    do_reset();
    p0_read = 1; p0_addr = 28'h0000010;
    exp_q.push_back('{port: 1'b0, wr: 1'b0, addr: 28'h0000010, wdata: '0});
    n_checks++;
    if (mem_read !== 1'b0) begin n_fail++; $display("FAIL early_req got=%0b required=0", mem_read); end
    serve(4, {16{8'hA5}}, 0, 1);
  endtask

  task automatic test_simultaneous();
    do_reset();
    p0_read = 1; p0_addr = 28'h1;
    p1_write = 1; p1_addr = 28'h2; p1_wdata = 128'h1234;
    exp_q.push_back('{port: 1'b0, wr: 1'b0, addr: 28'h1, wdata: '0});
    exp_q.push_back('{port: 1'b1, wr: 1'b1, addr: 28'h2, wdata: 128'h1234});
    @(posedge clk); #1;
    n_checks++;
    if ({d1_mem_write, d1_mem_read, d1_mem_addr, d1_mem_wdata} !== {1'b1, 1'b0, 28'h2, 128'h1234}) begin
      n_fail++; $display("FAIL prio_mode1 got w=%0b r=%0b a=%0h d=%0h required w=1 r=0 a=2 d=1234", d1_mem_write, d1_mem_read, d1_mem_addr, d1_mem_wdata);
    end
    serve(2, 128'h11, 0, 0);
    serve(2, 128'h22, 0, 2);
  endtask

  task automatic test_round_robin();
    do_reset();
    p0_read = 1; p0_addr = 28'hA0;
    p1_read = 1; p1_addr = 28'hB0;
    exp_q.push_back('{port: 1'b0, wr: 1'b0, addr: 28'hA0, wdata: '0});
    exp_q.push_back('{port: 1'b1, wr: 1'b0, addr: 28'hB0, wdata: '0});
    exp_q.push_back('{port: 1'b0, wr: 1'b0, addr: 28'hA1, wdata: '0});
    exp_q.push_back('{port: 1'b1, wr: 1'b0, addr: 28'hB1, wdata: '0});
    serve(3, 128'h1, 0, 1);
    p0_read = 1; p0_addr = 28'hA1;
    serve(3, 128'h2, 0, 2);
    p1_read = 1; p1_addr = 28'hB1;
    serve(3, 128'h3, 0, 2);
    serve(3, 128'h4, 0, 2);
  endtask

  task automatic test_stale_request();
    do_reset();
    p1_read = 1; p1_addr = 28'h5;
    exp_q.push_back('{port: 1'b1, wr: 1'b0, addr: 28'h5, wdata: '0});
    serve(2, 128'h55, 1, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({mem_read, mem_write, p1_ready} !== 3'b000) begin
        n_fail++; $display("FAIL stale_req cyc=%0d got r=%0b w=%0b rdy=%0b required 0", i, mem_read, mem_write, p1_ready);
      end
    end
  endtask

  task automatic test_read_write_both();
    do_reset();
    p0_read = 1; p0_write = 1; p0_addr = 28'h7; p0_wdata = 128'hCAFE;
    exp_q.push_back('{port: 1'b0, wr: 1'b1, addr: 28'h7, wdata: 128'hCAFE});
    serve(2, 128'h0, 0, 1);
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    p0_read = 1; p0_addr = 28'h9;
    @(posedge clk); #1;
    n_checks++;
    if (mem_read !== 1'b1) begin n_fail++; $display("FAIL busy_before_rst got=%0b required=1", mem_read); end
    #2; proc_reset_n = 1'b0; #1;
    n_checks++;
    if ({mem_read, mem_write, mem_addr} !== '0) begin
      n_fail++; $display("FAIL async_rst got r=%0b w=%0b a=%0h required 0", mem_read, mem_write, mem_addr);
    end
    mem_ready = 1'b1; #1;
    n_checks++;
    if ({p1_ready, p0_ready} !== 2'b00) begin n_fail++; $display("FAIL rst_ready got=%b required=00", {p1_ready, p0_ready}); end
    @(negedge clk);
    mem_ready = 1'b0;
    proc_reset_n = 1'b1;
    exp_q.push_back('{port: 1'b0, wr: 1'b0, addr: 28'h9, wdata: '0});
    serve(2, 128'h99, 0, 1);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_round_robin();
    test_stale_request();
    test_read_write_both();
    test_reset_mid_busy();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover got=%0d required=0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that lets the instruction cache (port 0) and the data cache (port 1) share one slow block-wide memory interface.
- Each cache drives its normal memory-side handshake into a port: read/write request, 28-bit block address, 128-bit block, ready pulse.
- The arbiter grants one port at a time and latches the winning request.
- It forwards only the granted port's request to memory and routes the memory's ready back to that port alone.

Parameters:
- ARB_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority to port 1 (D-cache).
- RELEASE_CYCLES, 1, dead cycles after each completed transaction during which all port requests are ignored (covers caches that sample ready one cycle late and hold the stale request); legal range 1..3.

Ports:
- clk  input  1  system clock, all state on rising edge
- proc_reset_n  input  1  asynchronous active-low reset
- p0_read  input  1  port 0 read request, held until p0_ready
- p0_write  input  1  port 0 write request, held until p0_ready
- p0_addr  input  28  port 0 block address
- p0_wdata  input  128  port 0 write block
- p0_rdata  output  128  read block for port 0
- p0_ready  output  1  port 0 transaction-complete pulse
- p1_read  input  1  port 1 read request
- p1_write  input  1  port 1 write request
- p1_addr  input  28  port 1 block address
- p1_wdata  input  128  port 1 write block
- p1_rdata  output  128  read block for port 1
- p1_ready  output  1  port 1 transaction-complete pulse
- mem_read  output  1  memory read request (registered)
- mem_write  output  1  memory write request (registered)
- mem_addr  output  28  memory block address (registered)
- mem_wdata  output  128  memory write block (registered)
- mem_rdata  input  128  memory read block
- mem_ready  input  1  memory completion, one cycle

Behaviour:
- Reset (async, proc_reset_n=0): state=IDLE, grant=0, rr_last=1 (port 0 wins the first tie), release counter=0.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0 immediately, not at the next edge.
  - Reset during BUSY abandons the transaction; no pX_ready is issued.
- Port request: reqX = pX_read | pX_write. If both read and write are asserted on one port, it is treated as a write (mem_write=1, mem_read=0 forwarded).
- FSM IDLE:
  - If no request, stay in IDLE.
  - If a request exists, select the winner.
    - ARB_MODE=0: the port not equal to rr_last wins when both request.
    - ARB_MODE=1: port 1 wins when both request.
  - At the edge: latch op, addr and wdata into the mem_* registers, set grant, set rr_last=grant, and go to BUSY.
  - Memory sees the request one cycle after the port first asserts it.
- FSM BUSY:
  - mem_* hold the latched values; port-side input changes are ignored.
  - When mem_ready=1: p<grant>_ready=1 in that same cycle (combinational), and the other port's ready stays 0.
  - At the edge after mem_ready: clear mem_read/mem_write, load the release counter with RELEASE_CYCLES, and go to RELEASE.
- FSM RELEASE:
  - No forwarding and no grant decisions; the counter decrements each cycle.
  - Go to IDLE when the counter reaches 1.
  - Minimum port-to-port turnaround is RELEASE_CYCLES+1 cycles after mem_ready.
- Read data: p0_rdata and p1_rdata both equal mem_rdata combinationally at all times. Only the ready pulse qualifies the data.
- pX_ready is never asserted outside BUSY. mem_ready arriving in IDLE or RELEASE is ignored.
- Starvation bound (ARB_MODE=0): a continuously requesting port waits at most one foreign transaction.

Optional Feature:
- Macro MEM_ARBITER_PERF_CNT_EN.
- When defined, adds outputs perf_grant0[15:0], perf_grant1[15:0] and perf_wait[15:0]:
  - perf_grantX increments once per completed port X transaction (on the pX_ready cycle).
  - perf_wait increments each cycle where a port requests but is not in BUSY as the granted port.
  - All counters saturate at 16'hFFFF and clear on reset.
- When undefined, these ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
- Single read: p0_read=1, p0_addr=28'h0000010; memory returns 128'hA5A5...A5 with mem_ready 4 cycles later -> mem_read=1, mem_addr=28'h0000010 from the next cycle; p0_ready=1 for exactly one cycle with p0_rdata=128'hA5A5...A5; p1_ready stays 0.
- Simultaneous requests, ARB_MODE=0, after reset: p0_read (addr 28'h1) and p1_write (addr 28'h2, wdata 128'h1234) both held -> port 0 is served first; after mem_ready plus 1 RELEASE cycle, mem_write=1, mem_addr=28'h2, mem_wdata=128'h1234.
- Same stimulus, ARB_MODE=1 -> port 1 is served first.
- Stale request: p1_read stays held for 1 cycle after p1_ready, RELEASE_CYCLES=1 -> no second memory read is issued; mem_read stays 0 through RELEASE and the following IDLE.
- Both p0_read and p0_write asserted with addr 28'h7 -> mem_write=1, mem_read=0, mem_addr=28'h7.
- proc_reset_n pulled low mid-BUSY -> mem_read/mem_write drop to 0 asynchronously; no pX_ready; after release, the first request is granted normally from IDLE.
